// File: rtl/check_scoreboard_pkg.sv
// Shared types and helpers for the check scoreboard.
// - log_entry_t: one failure-log record {ch, tag, expected, actual}, sized for the
//   largest supported configuration; narrower instances zero-extend into it.
// - state_e:     RUN/FROZEN control state.
// - sat_add:     saturating add clipped to an arbitrary counter width.
package check_scoreboard_pkg;

  // Log record field widths cover N_CH <= 16, TAG_W <= 16 and DATA_W <= 32.
  localparam int unsigned LogChW   = 4;
  localparam int unsigned LogTagW  = 16;
  localparam int unsigned LogDataW = 32;
  localparam int unsigned CntMaxW  = 32;

  typedef struct packed {
    logic [LogChW-1:0]   ch;
    logic [LogTagW-1:0]  tag;
    logic [LogDataW-1:0] expected;
    logic [LogDataW-1:0] actual;
  } log_entry_t;

  typedef enum logic {
    StRun,
    StFrozen
  } state_e;

  // Returns min(a + b, 2**width - 1); width must be 1..CntMaxW.
  function automatic logic [CntMaxW-1:0] sat_add(input logic [CntMaxW-1:0] a,
                                                 input logic [CntMaxW-1:0] b,
                                                 input int unsigned        width);
    logic [CntMaxW:0] sum;
    logic [CntMaxW:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((CntMaxW+1)'(1) << width) - (CntMaxW+1)'(1);
    if (sum > lim) begin
      return lim[CntMaxW-1:0];
    end
    return sum[CntMaxW-1:0];
  endfunction

endpackage

// File: rtl/check_log_fifo.sv
// Synchronous FIFO of failure-log records.
// Ports: clk/rst_n, clear_i (synchronous flush), push_i/wdata_i/full_o,
//        pop_i/rdata_o/empty_o. rdata_o is the head entry, forced to zero when empty.
// A push while full is accepted only if a pop happens in the same cycle.
module check_log_fifo
  import check_scoreboard_pkg::*;
#(
  parameter int unsigned LOG_DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       push_i,
  input  log_entry_t wdata_i,
  output logic       full_o,
  input  logic       pop_i,
  output log_entry_t rdata_o,
  output logic       empty_o
);

  localparam int unsigned AddrW = $clog2(LOG_DEPTH);
  localparam logic [AddrW:0] PtrOne = (AddrW+1)'(1);

  log_entry_t       mem_q [LOG_DEPTH];
  // Extra MSB distinguishes full from empty when the address bits match.
  logic [AddrW:0]   wptr_q, wptr_d;
  logic [AddrW:0]   rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                   (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear_i) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PtrOne;
      if (do_pop)  rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) begin
      mem_q[wptr_q[AddrW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AddrW-1:0]];

endmodule

// File: rtl/check_scoreboard.sv
// Multi-channel expected/actual checker with saturating pass/fail/drop counters
// and a drainable failure log.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   clear_i              synchronous clear of counters, log and freeze
//   chk_*_i              per-channel valid / expected / actual / mask / tag
//   pass/fail/drop_count_o, frozen_o, all_pass_o   summary outputs
//   log_valid_o/log_ready_i + log_ch/tag/expected/actual_o   log head handshake
module check_scoreboard
  import check_scoreboard_pkg::*;
#(
  parameter int unsigned  N_CH         = 4,
  parameter int unsigned  DATA_W       = 32,
  parameter int unsigned  TAG_W        = 16,
  parameter int unsigned  LOG_DEPTH    = 16,
  parameter int unsigned  CNT_W        = 32,
  parameter bit           STOP_ON_FAIL = 1'b0,
  localparam int unsigned CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic [N_CH-1:0]          chk_valid_i,
  input  logic [N_CH*DATA_W-1:0]   chk_expected_i,
  input  logic [N_CH*DATA_W-1:0]   chk_actual_i,
  input  logic [N_CH*DATA_W-1:0]   chk_mask_i,
  input  logic [N_CH*TAG_W-1:0]    chk_tag_i,
  output logic [CNT_W-1:0]         pass_count_o,
  output logic [CNT_W-1:0]         fail_count_o,
  output logic [CNT_W-1:0]         drop_count_o,
  output logic                     frozen_o,
  output logic                     all_pass_o,
  output logic                     log_valid_o,
  input  logic                     log_ready_i,
  output logic [CH_W-1:0]          log_ch_o,
  output logic [TAG_W-1:0]         log_tag_o,
  output logic [DATA_W-1:0]        log_expected_o,
  output logic [DATA_W-1:0]        log_actual_o
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   pass_q, pass_d;
  logic [CNT_W-1:0]   fail_q, fail_d;
  logic [CNT_W-1:0]   drop_q, drop_d;

  logic               run;
  logic [N_CH-1:0]    pass_vec, fail_vec;
  logic [CntMaxW-1:0] n_pass, n_fail, n_drop;
  logic               any_fail;
  logic [CH_W-1:0]    sel_ch;
  logic [TAG_W-1:0]   sel_tag;
  logic [DATA_W-1:0]  sel_exp, sel_act;

  logic               fifo_full, fifo_empty, fifo_push, fifo_pop;
  log_entry_t         wr_entry, head;
  logic               unused_head;

  // Frozen state masks every compare so nothing further is counted or logged.
  assign run = (state_q == StRun);

  always_comb begin : compare
    pass_vec = '0;
    fail_vec = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (chk_valid_i[i] && run) begin
        if (|((chk_expected_i[i*DATA_W +: DATA_W] ^ chk_actual_i[i*DATA_W +: DATA_W]) &
              chk_mask_i[i*DATA_W +: DATA_W])) begin
          fail_vec[i] = 1'b1;
        end else begin
          pass_vec[i] = 1'b1;
        end
      end
    end
  end

  // Popcounts plus lowest-index failing channel selection.
  always_comb begin : tally
    n_pass   = '0;
    n_fail   = '0;
    any_fail = 1'b0;
    sel_ch   = '0;
    sel_tag  = '0;
    sel_exp  = '0;
    sel_act  = '0;
    for (int i = 0; i < N_CH; i++) begin
      n_pass = n_pass + CntMaxW'(pass_vec[i]);
      n_fail = n_fail + CntMaxW'(fail_vec[i]);
      if (fail_vec[i] && !any_fail) begin
        any_fail = 1'b1;
        sel_ch   = CH_W'(i);
        sel_tag  = chk_tag_i[i*TAG_W +: TAG_W];
        sel_exp  = chk_expected_i[i*DATA_W +: DATA_W];
        sel_act  = chk_actual_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // A same-cycle pop frees a slot, so a full log still accepts the write.
  assign log_valid_o = ~fifo_empty;
  assign fifo_pop    = log_valid_o & log_ready_i & ~clear_i;
  assign fifo_push   = any_fail & (~fifo_full | fifo_pop) & ~clear_i;
  assign n_drop      = n_fail - CntMaxW'(fifo_push);

  always_comb begin
    wr_entry          = '0;
    wr_entry.ch       = LogChW'(sel_ch);
    wr_entry.tag      = LogTagW'(sel_tag);
    wr_entry.expected = LogDataW'(sel_exp);
    wr_entry.actual   = LogDataW'(sel_act);
  end

  check_log_fifo #(
    .LOG_DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear_i),
    .push_i  (fifo_push),
    .wdata_i (wr_entry),
    .full_o  (fifo_full),
    .pop_i   (fifo_pop),
    .rdata_o (head),
    .empty_o (fifo_empty)
  );

  // Head is all-zero while empty, so these outputs read 0 when log_valid_o is low.
  assign log_ch_o       = CH_W'(head.ch);
  assign log_tag_o      = TAG_W'(head.tag);
  assign log_expected_o = DATA_W'(head.expected);
  assign log_actual_o   = DATA_W'(head.actual);
  assign unused_head    = ^head;

  always_comb begin
    state_d = state_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    drop_d  = drop_q;
    if (clear_i) begin
      state_d = StRun;
      pass_d  = '0;
      fail_d  = '0;
      drop_d  = '0;
    end else begin
      pass_d = CNT_W'(sat_add(CntMaxW'(pass_q), n_pass, CNT_W));
      fail_d = CNT_W'(sat_add(CntMaxW'(fail_q), n_fail, CNT_W));
      drop_d = CNT_W'(sat_add(CntMaxW'(drop_q), n_drop, CNT_W));
      // The failing cycle itself is still counted and logged above.
      if (STOP_ON_FAIL && any_fail) begin
        state_d = StFrozen;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      pass_q  <= '0;
      fail_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      drop_q  <= drop_d;
    end
  end

  assign pass_count_o = pass_q;
  assign fail_count_o = fail_q;
  assign drop_count_o = drop_q;
  assign frozen_o     = (state_q == StFrozen);
  assign all_pass_o   = (fail_q == '0) && (pass_q != '0);

endmodule

// File: tb/tb_check_scoreboard.sv
// Bench for check_scoreboard: two instances share stimulus. u_dut uses default
// parameters with a handshaken log; u_sat uses CNT_W=4, STOP_ON_FAIL=1 with the log
// always drained. A behavioural model predicts counters and log contents; the
// monitor compares every cycle and pops expected log entries on each handshake.
module tb_check_scoreboard;

  localparam int N_CH  = 4;
  localparam int DW    = 32;
  localparam int TW    = 16;
  localparam int DEPTH = 16;
  localparam longint MAX32 = 64'hFFFF_FFFF;
  localparam longint MAX4  = 15;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 clear = 1'b0;
  logic [N_CH-1:0]      chk_valid = '0;
  logic [N_CH*DW-1:0]   chk_exp = '0;
  logic [N_CH*DW-1:0]   chk_act = '0;
  logic [N_CH*DW-1:0]   chk_mask = '0;
  logic [N_CH*TW-1:0]   chk_tag = '0;
  logic                 log_ready = 1'b0;

  logic [31:0] pass_count, fail_count, drop_count;
  logic        frozen, all_pass, log_valid;
  logic [1:0]  log_ch;
  logic [15:0] log_tag;
  logic [31:0] log_exp, log_act;

  logic [3:0]  s_pass, s_fail, s_drop;
  logic        s_frozen, s_all_pass, s_log_valid;
  logic [1:0]  s_log_ch;
  logic [15:0] s_log_tag;
  logic [31:0] s_log_exp, s_log_act;

  always #5 clk = ~clk;

  check_scoreboard #(
    .N_CH(N_CH), .DATA_W(DW), .TAG_W(TW), .LOG_DEPTH(DEPTH), .CNT_W(32), .STOP_ON_FAIL(1'b0)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .chk_valid_i(chk_valid), .chk_expected_i(chk_exp), .chk_actual_i(chk_act),
    .chk_mask_i(chk_mask), .chk_tag_i(chk_tag),
    .pass_count_o(pass_count), .fail_count_o(fail_count), .drop_count_o(drop_count),
    .frozen_o(frozen), .all_pass_o(all_pass), .log_valid_o(log_valid),
    .log_ready_i(log_ready), .log_ch_o(log_ch), .log_tag_o(log_tag),
    .log_expected_o(log_exp), .log_actual_o(log_act)
  );

  check_scoreboard #(
    .N_CH(N_CH), .DATA_W(DW), .TAG_W(TW), .LOG_DEPTH(4), .CNT_W(4), .STOP_ON_FAIL(1'b1)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .clear_i(clear),
    .chk_valid_i(chk_valid), .chk_expected_i(chk_exp), .chk_actual_i(chk_act),
    .chk_mask_i(chk_mask), .chk_tag_i(chk_tag),
    .pass_count_o(s_pass), .fail_count_o(s_fail), .drop_count_o(s_drop),
    .frozen_o(s_frozen), .all_pass_o(s_all_pass), .log_valid_o(s_log_valid),
    .log_ready_i(1'b1), .log_ch_o(s_log_ch), .log_tag_o(s_log_tag),
    .log_expected_o(s_log_exp), .log_actual_o(s_log_act)
  );

  // ---------------- scoring ----------------
  int n_checks = 0;
  int n_passed = 0;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
  endtask

  function automatic longint sat(input longint v, input longint mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int          ch;
    logic [15:0] tag;
    logic [31:0] e;
    logic [31:0] a;
  } ent_t;

  ent_t   exp_q[$];
  longint m_pass = 0, m_fail = 0, m_drop = 0;
  longint s_m_pass = 0, s_m_fail = 0, s_m_drop = 0;
  bit     s_m_frozen = 1'b0;

  // Applies one clock's worth of compares. exp_q already reflects this cycle's pop
  // (the monitor removed it half a cycle earlier), i.e. the read is considered first.
  initial begin : model
    int np, nf;
    logic [31:0] e, a, m;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n || clear) begin
        m_pass = 0; m_fail = 0; m_drop = 0;
        s_m_pass = 0; s_m_fail = 0; s_m_drop = 0; s_m_frozen = 1'b0;
        exp_q.delete();
      end else begin
        np = 0;
        nf = 0;
        for (int c = 0; c < N_CH; c++) begin
          if (chk_valid[c]) begin
            e = chk_exp[c*DW +: DW];
            a = chk_act[c*DW +: DW];
            m = chk_mask[c*DW +: DW];
            if (((e ^ a) & m) == 32'd0) np++;
            else begin
              nf++;
              if (nf == 1 && exp_q.size() < DEPTH)
                exp_q.push_back('{ch: c, tag: chk_tag[c*TW +: TW], e: e, a: a});
              else m_drop++;
            end
          end
        end
        m_pass = sat(m_pass + np, MAX32);
        m_fail = sat(m_fail + nf, MAX32);
        m_drop = sat(m_drop, MAX32);
        // u_sat drains its log every cycle, so only same-cycle extras are dropped.
        if (!s_m_frozen) begin
          s_m_pass = sat(s_m_pass + np, MAX4);
          s_m_fail = sat(s_m_fail + nf, MAX4);
          if (nf > 1) s_m_drop = sat(s_m_drop + nf - 1, MAX4);
          if (nf > 0) s_m_frozen = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    ent_t h;
    forever begin
      @(negedge clk);
      check("pass_count", pass_count, m_pass);
      check("fail_count", fail_count, m_fail);
      check("drop_count", drop_count, m_drop);
      check("frozen", frozen, 0);
      check("all_pass", all_pass, (m_fail == 0 && m_pass != 0) ? 1 : 0);
      check("log_valid", log_valid, (exp_q.size() > 0) ? 1 : 0);
      if (!log_valid) begin
        check("idle_fields_zero", |{log_ch, log_tag, log_exp, log_act}, 0);
      end else if (log_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          h = exp_q.pop_front();
          check("log_ch", log_ch, h.ch);
          check("log_tag", log_tag, h.tag);
          check("log_expected", log_exp, h.e);
          check("log_actual", log_act, h.a);
        end
      end
      check("sat_pass", s_pass, s_m_pass);
      check("sat_fail", s_fail, s_m_fail);
      check("sat_drop", s_drop, s_m_drop);
      check("sat_frozen", s_frozen, s_m_frozen);
      check("sat_all_pass", s_all_pass, (s_m_fail == 0 && s_m_pass != 0) ? 1 : 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c, input logic [31:0] e, input logic [31:0] a,
                       input logic [31:0] m, input logic [15:0] t);
    chk_valid[c]          = 1'b1;
    chk_exp[c*DW +: DW]   = e;
    chk_act[c*DW +: DW]   = a;
    chk_mask[c*DW +: DW]  = m;
    chk_tag[c*TW +: TW]   = t;
  endtask

  task automatic rand_cycle();
    logic [31:0] e, a, m;
    for (int c = 0; c < N_CH; c++) begin
      e = $urandom;
      case ($urandom_range(0, 3))
        0:       m = 32'd0;
        1:       m = 32'hFFFF_FFFF;
        default: m = $urandom;
      endcase
      a = ($urandom_range(0, 1) == 0) ? e : (e ^ (32'd1 << $urandom_range(0, 31)));
      drive(c, e, a, m, 16'($urandom));
      chk_valid[c] = 1'($urandom_range(0, 1));
    end
    log_ready = 1'($urandom_range(0, 1));
    clear     = ($urandom_range(0, 49) == 0);
  endtask

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    check("rst_pass", pass_count, 0);
    check("rst_log_valid", log_valid, 0);
    check("rst_all_pass", all_pass, 0);
    rst_n = 1'b1;
    tick();

    // Single channel pass then fail.
    drive(0, 32'd5, 32'd5, ONES, 16'h0001);
    tick(); chk_valid = '0;
    check("A_pass", pass_count, 1);
    check("A_fail", fail_count, 0);
    check("A_all_pass", all_pass, 1);
    check("A_log_valid", log_valid, 0);

    drive(0, 32'd5, 32'd7, ONES, 16'h0002);
    tick(); chk_valid = '0;
    check("B_fail", fail_count, 1);
    check("B_log_valid", log_valid, 1);
    check("B_log_ch", log_ch, 0);
    check("B_log_exp", log_exp, 5);
    check("B_log_act", log_act, 7);
    tick();
    check("B_hold_exp", log_exp, 5);
    log_ready = 1'b1;
    tick(); log_ready = 1'b0;
    check("B_popped", log_valid, 0);

    // Masking, including an all-zero mask.
    drive(0, 32'hFF00, 32'hFF0F, 32'hFF00, 16'h0003);
    tick(); chk_valid = '0;
    check("C_mask_pass", pass_count, 2);
    drive(0, 32'hFF00, 32'hFF0F, 32'h000F, 16'h0004);
    tick(); chk_valid = '0;
    check("C_mask_fail", fail_count, 2);
    drive(1, 32'd1, 32'd2, 32'd0, 16'h0005);
    tick(); chk_valid = '0;
    check("C_zero_mask", pass_count, 3);

    // Two failures in one cycle: ch1 logged, ch3 dropped.
    drive(1, 32'h11, 32'h10, ONES, 16'h0011);
    drive(3, 32'h33, 32'h30, ONES, 16'h0033);
    tick(); chk_valid = '0;
    check("D_fail", fail_count, 4);
    check("D_drop", drop_count, 1);
    log_ready = 1'b1;
    repeat (3) tick();
    log_ready = 1'b0;
    check("D_drained", log_valid, 0);

    // Fill the log: 17 failures, the last one dropped.
    for (int i = 0; i < 17; i++) begin
      drive(2, 32'(i), 32'(i + 100), ONES, 16'(16'h200 + i));
      tick();
    end
    chk_valid = '0;
    check("E_fail", fail_count, 21);
    check("E_drop", drop_count, 2);
    // Failure on a full+pop cycle is accepted.
    log_ready = 1'b1;
    drive(2, 32'hAAAA, 32'hBBBB, ONES, 16'h03FF);
    tick(); chk_valid = '0;
    check("E_no_drop", drop_count, 2);
    repeat (17) tick();
    check("E_empty", log_valid, 0);
    log_ready = 1'b0;

    clear = 1'b1;
    tick(); clear = 1'b0;
    check("F_pass", pass_count, 0);
    check("F_drop", drop_count, 0);
    check("F_sat_fail", s_fail, 0);

    // Freeze on first fail in u_sat.
    drive(0, 32'd1, 32'd1, ONES, 16'h0);
    tick(); chk_valid = '0;
    drive(2, 32'd1, 32'd0, ONES, 16'h0022);
    tick(); chk_valid = '0;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < N_CH; c++) drive(c, 32'(i), 32'(i), ONES, 16'h0);
      tick();
    end
    chk_valid = '0;
    check("G_sat_fail", s_fail, 1);
    check("G_sat_pass", s_pass, 1);
    check("G_sat_frozen", s_frozen, 1);
    clear = 1'b1;
    tick(); clear = 1'b0;
    check("G_clr_pass", s_pass, 0);
    check("G_clr_frozen", s_frozen, 0);

    // Saturation of a 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      drive(0, 32'(i), 32'(i), ONES, 16'h0);
      tick();
    end
    chk_valid = '0;
    check("H_sat_pass", s_pass, 15);
    check("H_dut_pass", pass_count, 20);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      rand_cycle();
      tick();
    end
    clear = 1'b0;

    // Asynchronous reset mid-burst.
    for (int c = 0; c < N_CH; c++) drive(c, 32'd9, 32'd9, ONES, 16'h0);
    log_ready = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("J_rst_pass", pass_count, 0);
    check("J_rst_fail", fail_count, 0);
    check("J_rst_log_valid", log_valid, 0);
    check("J_rst_sat_pass", s_pass, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rand_cycle();
      clear = 1'b0;
      tick();
    end
    chk_valid = '0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
